mem_handshake_controller: RTL and testbench
===========================================

# mem_handshake_controller

Parametrised successor to the multi-cycle datapath controller of the RISC machine. It sequences fetch, PC update, decode, execute, memory and writeback for the existing instruction set. It adds:
- a variable-latency memory handshake (`mem_ready`) with a timeout fault;
- a resumable halt;
- a retired-instruction counter.

It sits between the instruction decoder/status register and the PC, IR, RAM and datapath.

## Interface
- `CNT_W`, 16: width of `instr_count`.
- `MEM_TIMEOUT`, 15: maximum consecutive `mem_ready`-low cycles allowed in a memory state; 0 disables the timeout.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `status` in 3: {N,V,Z} from the status register.
- `opcode` in 3, `op` in 2, `cond` in 3: from the instruction decoder.
- `mem_ready` in 1: memory read data valid / write accepted this cycle.
- `resume` in 1: leave HALT.
- `reset_pc`, `tsel`, `execb`, `rsel`, `addr_sel`, `load_addr` out 1: PC and address control.
- `mem_cmd` out 2: 10 = read, 01 = write, 00 = none.
- `load_ir` out 1: IR load.
- `nsel` out 3: one-hot register select; Rn = 100, Rd = 010, Rm = 001.
- `vsel` out 2: writeback source; 00 = C, 01 = PC (link), 10 = sximm8, 11 = mdata.
- `write`, `asel`, `bsel`, `loada`, `loadb`, `loadc`, `loads` out 1: datapath control.
- `halted`, `fault` out 1: in HALT / in FAULT.
- `retire` out 1: last cycle of an instruction.
- `instr_count` out CNT_W: saturating count of retired instructions.

## Operation
- Outputs are decoded combinationally from state, opcode/op and, in memory states, `mem_ready`.
- Every output is 0 unless listed for the current state.
- Opcodes: MOV = 110, ALU = 101, LDR = 011, STR = 100, B = 001, C = 010, HLT = 111.

States and transitions:
- **RESET**: `reset_pc` = `rsel` = 1; next IFETCH.
- **IFETCH** (memory state): `addr_sel` = 1, `mem_cmd` = 10, `load_ir` = `mem_ready`. Stays put until `mem_ready`, then goes to PC_UPDATE.
- **PC_UPDATE**, branches (opcode B, op 00):
  - Taken conditions: cond 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V) or Z.
  - Taken: `execb` = 1. Not taken: `rsel` = 1.
  - Both go to IFETCH with `retire` = 1.
- **PC_UPDATE**, calls and returns (opcode C):
  - BL (op 11, cond 111) and BLX (op 10, cond 111): `vsel` = 01, `write` = 1, `nsel` = Rn; next JUMP_RETURN.
  - BX (op 00, cond 000): `nsel` = Rd, `loada` = 1; next JUMP_RETURN.
- **PC_UPDATE**, all other instructions: `rsel` = 1; next DECODE.
- **JUMP_RETURN**:
  - BL: `execb` = 1, `retire` = 1; next IFETCH.
  - BLX: `nsel` = Rd, `loada` = 1; next BLX_RETURN.
  - BX: `tsel` = 1, `retire` = 1; next IFETCH.
- **BLX_RETURN**: `tsel` = 1, `retire` = 1; next IFETCH.
- **DECODE** dispatch:
  - MOV/op 10 → MOV_IMM.
  - MOV/op 00 and ALU/op 11 (MVN) → READ_B.
  - Other ALU ops, LDR/op 00 and STR/op 00 → READ_A.
  - HLT → HALT with `retire` = 1.
  - Anything else → FAULT, no retire.
- **MOV_IMM**: `vsel` = 10, `write` = 1, `nsel` = Rn, `retire` = 1; next IFETCH.
- **READ_A**: `nsel` = Rn, `loada` = 1. ALU goes to READ_B; LDR/STR go to COMPUTE.
- **READ_B**: `nsel` = Rm, `loadb` = 1; next COMPUTE.
- **COMPUTE**: `loadc` = 1, plus:
  - MOV: `asel` = 1; next WRITEBACK.
  - MVN, ADD, AND: next WRITEBACK.
  - CMP (ALU op 01): `loads` = 1, `retire` = 1; next IFETCH.
  - LDR/STR: `bsel` = 1; next DA_UPDATE.
- **WRITEBACK**: `nsel` = Rd, `write` = 1, `retire` = 1; next IFETCH.
- **DA_UPDATE**: `load_addr` = 1; LDR goes to LDR_READ, STR goes to STR_READ.
- **LDR_READ** (memory state): `mem_cmd` = 10, `nsel` = Rd, `vsel` = 11, `write` = `mem_ready`. On `mem_ready`: `retire` = 1, next IFETCH.
- **STR_READ**: `nsel` = Rd, `loadb` = 1; next STR_LOAD.
- **STR_LOAD**: `loadc` = 1, `asel` = 1; next STR_WRITE.
- **STR_WRITE** (memory state): `mem_cmd` = 01. On `mem_ready`: `retire` = 1, next IFETCH.
- **HALT**: `halted` = 1. On `resume`, go to IFETCH; the PC already points past the HLT.
- **FAULT**: `fault` = 1 and `mem_cmd` = 00. It is left only by `reset`.

Wait counter:
- Width is clog2(MEM_TIMEOUT+1).
- Increments each cycle a memory state sees `mem_ready` = 0.
- Cleared on leaving the state, or on `mem_ready` = 1.
- When it reaches MEM_TIMEOUT with `mem_ready` still 0, the next state is FAULT.

`instr_count` increments on every edge where `retire` = 1 and saturates at all-ones.

## Timing
- Reset:
  - On any edge with `reset` = 1, the state becomes RESET and both `instr_count` and the wait counter become 0.
  - After that edge, outputs are `reset_pc` = `rsel` = 1 and all others 0, including `halted` = `fault` = `retire` = 0.
  - `reset` overrides `resume`, `mem_ready` and an in-progress memory wait; `mem_cmd` drops to 00 after that edge.
- Cycle counts with zero-wait memory (`mem_ready` held 1):
  - MOV imm: 4 cycles.
  - ADD/AND: 7 cycles.
  - CMP: 6 cycles.
  - LDR: 7 cycles.
  - STR: 9 cycles.
  - Branch: 2 cycles.
  - BL/BX: 3 cycles.
  - BLX: 4 cycles.
- Each low `mem_ready` cycle adds exactly 1 cycle. `mem_cmd` and `addr_sel` are held stable for the whole wait.
- `mem_ready` outside memory states is ignored.
- `resume` is ignored outside HALT. `resume` held high entering HALT takes effect on the next edge.

## Test plan
- Reset, then MOV R0,#5 with `mem_ready` tied 1 → states RESET, IFETCH, PC_UPDATE, DECODE, MOV_IMM, IFETCH; `write` = 1 with `vsel` = 10 and `nsel` = 100 in cycle 4; `instr_count` = 1.
- LDR with `mem_ready` low 3 cycles in LDR_READ → `mem_cmd` = 10 held 4 cycles; `write` pulses once, in the `mem_ready` cycle; total 10 cycles.
- STR with `mem_ready` held 0, MEM_TIMEOUT = 15 → FAULT entered exactly 15 cycles after entering STR_WRITE; `fault` = 1 and `mem_cmd` = 00 until reset.
- BLT with `status` = 100 then 101 (taken; N≠V), and `status` = 000 (not taken) → `execb` = 1 in the first case, `rsel` = 1 in the second, 2 cycles each.
- HLT then `resume` pulse → `halted` = 1 until the edge after `resume`, then IFETCH; `instr_count` increments at the HLT.
- Reset asserted mid-IFETCH wait, and with CNT_W = 2 after 5 retires → RESET state next edge; `instr_count` saturates at 3 before the reset and reads 0 after it.

Source files
------------

// File: rtl/mem_handshake_controller.sv
// Multi-cycle RISC datapath controller with a variable-latency memory
// handshake, a memory-wait timeout fault, resumable halt and retire counter.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   status {N,V,Z}        : flags for conditional branches
//   opcode, op, cond      : fields from the instruction decoder
//   mem_ready             : memory read data valid / write accepted
//   resume                : leave HALT
//   reset_pc .. load_addr : PC and address control
//   mem_cmd               : 10 read, 01 write, 00 idle
//   load_ir               : instruction register load
//   nsel, vsel, write,
//   asel, bsel, loada..s  : register file and datapath control
//   halted, fault         : controller is in HALT / FAULT
//   retire, instr_count   : last cycle of an instruction, saturating count
module mem_handshake_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       status,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic [2:0]       cond,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             reset_pc,
    output logic             tsel,
    output logic             execb,
    output logic             rsel,
    output logic             addr_sel,
    output logic             load_addr,
    output logic [1:0]       mem_cmd,
    output logic             load_ir,
    output logic [2:0]       nsel,
    output logic [1:0]       vsel,
    output logic             write,
    output logic             asel,
    output logic             bsel,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             halted,
    output logic             fault,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] OPC_B   = 3'b001;
    localparam logic [2:0] OPC_C   = 3'b010;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_HLT = 3'b111;

    localparam logic [2:0] SEL_RN = 3'b100;
    localparam logic [2:0] SEL_RD = 3'b010;
    localparam logic [2:0] SEL_RM = 3'b001;

    typedef enum logic [4:0] {
        S_RESET,
        S_IFETCH,
        S_PC_UPDATE,
        S_JUMP_RETURN,
        S_BLX_RETURN,
        S_DECODE,
        S_MOV_IMM,
        S_READ_A,
        S_READ_B,
        S_COMPUTE,
        S_WRITEBACK,
        S_DA_UPDATE,
        S_LDR_READ,
        S_STR_READ,
        S_STR_LOAD,
        S_STR_WRITE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;

    logic is_b;
    logic is_bl;
    logic is_blx;
    logic is_bx;
    logic is_mov;
    logic is_alu;
    logic is_ldr;
    logic is_str;
    logic taken;
    logic mem_state;
    logic timeout;

    assign is_b   = (opcode == OPC_B) && (op == 2'b00);
    assign is_bl  = (opcode == OPC_C) && (op == 2'b11) && (cond == 3'b111);
    assign is_blx = (opcode == OPC_C) && (op == 2'b10) && (cond == 3'b111);
    assign is_bx  = (opcode == OPC_C) && (op == 2'b00) && (cond == 3'b000);
    assign is_mov = (opcode == OPC_MOV);
    assign is_alu = (opcode == OPC_ALU);
    assign is_ldr = (opcode == OPC_LDR);
    assign is_str = (opcode == OPC_STR);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = status[0];
            3'b010:  taken = !status[0];
            3'b011:  taken = status[2] ^ status[1];
            3'b100:  taken = (status[2] ^ status[1]) | status[0];
            default: taken = 1'b0;
        endcase
    end

    assign mem_state = (state == S_IFETCH) || (state == S_LDR_READ) ||
                       (state == S_STR_WRITE);

    // Fires on the low cycle that would bring the count to MEM_TIMEOUT.
    assign timeout = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                     (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        next_state = state;
        reset_pc   = 1'b0;
        tsel       = 1'b0;
        execb      = 1'b0;
        rsel       = 1'b0;
        addr_sel   = 1'b0;
        load_addr  = 1'b0;
        mem_cmd    = 2'b00;
        load_ir    = 1'b0;
        nsel       = 3'b000;
        vsel       = 2'b00;
        write      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        retire     = 1'b0;
        unique case (state)
            S_RESET: begin
                reset_pc   = 1'b1;
                rsel       = 1'b1;
                next_state = S_IFETCH;
            end
            S_IFETCH: begin
                addr_sel = 1'b1;
                mem_cmd  = 2'b10;
                load_ir  = mem_ready;
                if (mem_ready)    next_state = S_PC_UPDATE;
                else if (timeout) next_state = S_FAULT;
            end
            S_PC_UPDATE: begin
                if (is_b) begin
                    execb      = taken;
                    rsel       = !taken;
                    retire     = 1'b1;
                    next_state = S_IFETCH;
                end else if (is_bl || is_blx) begin
                    vsel       = 2'b01;
                    write      = 1'b1;
                    nsel       = SEL_RN;
                    next_state = S_JUMP_RETURN;
                end else if (is_bx) begin
                    nsel       = SEL_RD;
                    loada      = 1'b1;
                    next_state = S_JUMP_RETURN;
                end else begin
                    rsel       = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_JUMP_RETURN: begin
                if (is_blx) begin
                    nsel       = SEL_RD;
                    loada      = 1'b1;
                    next_state = S_BLX_RETURN;
                end else if (is_bl) begin
                    execb      = 1'b1;
                    retire     = 1'b1;
                    next_state = S_IFETCH;
                end else begin
                    tsel       = 1'b1;
                    retire     = 1'b1;
                    next_state = S_IFETCH;
                end
            end
            S_BLX_RETURN: begin
                tsel       = 1'b1;
                retire     = 1'b1;
                next_state = S_IFETCH;
            end
            S_DECODE: begin
                if (is_mov && (op == 2'b10)) begin
                    next_state = S_MOV_IMM;
                end else if ((is_mov && (op == 2'b00)) ||
                             (is_alu && (op == 2'b11))) begin
                    next_state = S_READ_B;
                end else if (is_alu ||
                             ((is_ldr || is_str) && (op == 2'b00))) begin
                    next_state = S_READ_A;
                end else if (opcode == OPC_HLT) begin
                    retire     = 1'b1;
                    next_state = S_HALT;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_MOV_IMM: begin
                vsel       = 2'b10;
                write      = 1'b1;
                nsel       = SEL_RN;
                retire     = 1'b1;
                next_state = S_IFETCH;
            end
            S_READ_A: begin
                nsel       = SEL_RN;
                loada      = 1'b1;
                next_state = is_alu ? S_READ_B : S_COMPUTE;
            end
            S_READ_B: begin
                nsel       = SEL_RM;
                loadb      = 1'b1;
                next_state = S_COMPUTE;
            end
            S_COMPUTE: begin
                loadc = 1'b1;
                if (is_mov) begin
                    asel       = 1'b1;
                    next_state = S_WRITEBACK;
                end else if (is_alu) begin
                    if (op == 2'b01) begin
                        loads      = 1'b1;
                        retire     = 1'b1;
                        next_state = S_IFETCH;
                    end else begin
                        next_state = S_WRITEBACK;
                    end
                end else begin
                    bsel       = 1'b1;
                    next_state = S_DA_UPDATE;
                end
            end
            S_WRITEBACK: begin
                nsel       = SEL_RD;
                write      = 1'b1;
                retire     = 1'b1;
                next_state = S_IFETCH;
            end
            S_DA_UPDATE: begin
                load_addr  = 1'b1;
                next_state = is_ldr ? S_LDR_READ : S_STR_READ;
            end
            S_LDR_READ: begin
                mem_cmd = 2'b10;
                nsel    = SEL_RD;
                vsel    = 2'b11;
                write   = mem_ready;
                retire  = mem_ready;
                if (mem_ready)    next_state = S_IFETCH;
                else if (timeout) next_state = S_FAULT;
            end
            S_STR_READ: begin
                nsel       = SEL_RD;
                loadb      = 1'b1;
                next_state = S_STR_LOAD;
            end
            S_STR_LOAD: begin
                loadc      = 1'b1;
                asel       = 1'b1;
                next_state = S_STR_WRITE;
            end
            S_STR_WRITE: begin
                mem_cmd = 2'b01;
                retire  = mem_ready;
                if (mem_ready)    next_state = S_IFETCH;
                else if (timeout) next_state = S_FAULT;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) next_state = S_IFETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                next_state = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RESET;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            // Counts only while still stalled in the same memory state.
            if (mem_state && !mem_ready && (next_state == state))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (retire && !(&instr_count))
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_handshake_controller.sv
// Randomized self-checking bench for mem_handshake_controller.
// Expected per-instruction signal activity is derived from cycle tables.
module tb_mem_handshake_controller;

    localparam int K_MOVI = 0;
    localparam int K_MOVR = 1;
    localparam int K_MVN  = 2;
    localparam int K_ADD  = 3;
    localparam int K_AND  = 4;
    localparam int K_CMP  = 5;
    localparam int K_LDR  = 6;
    localparam int K_STR  = 7;
    localparam int K_B    = 8;
    localparam int K_BL   = 9;
    localparam int K_BLX  = 10;
    localparam int K_BX   = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] status = '0;
    logic [2:0] opcode = '0;
    logic [1:0] op = '0;
    logic [2:0] cond = '0;
    logic       mem_ready = 1'b0;
    logic       resume = 1'b0;

    logic        reset_pc, tsel, execb, rsel, addr_sel, load_addr;
    logic [1:0]  mem_cmd;
    logic        load_ir;
    logic [2:0]  nsel;
    logic [1:0]  vsel;
    logic        write, asel, bsel, loada, loadb, loadc, loads;
    logic        halted, fault, retire;
    logic [15:0] instr_count;

    logic        s_reset_pc, s_tsel, s_execb, s_rsel, s_addr_sel, s_load_addr;
    logic [1:0]  s_mem_cmd;
    logic        s_load_ir;
    logic [2:0]  s_nsel;
    logic [1:0]  s_vsel;
    logic        s_write, s_asel, s_bsel, s_loada, s_loadb, s_loadc, s_loads;
    logic        s_halted, s_fault, s_retire;
    logic [1:0]  sat_count;

    int n_tests = 0;
    int n_fail = 0;
    int exp_count = 0;

    string kname[12] = '{"MOVI", "MOVR", "MVN", "ADD", "AND", "CMP",
                         "LDR", "STR", "B", "BL", "BLX", "BX"};
    string cname[16] = '{"cycles", "rd_cycles", "wr_cycles", "write",
                         "execb", "tsel", "rsel", "loads", "loada",
                         "loadb", "loadc", "asel", "bsel", "load_addr",
                         "load_ir", "addr_sel"};

    mem_handshake_controller #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .status(status), .opcode(opcode),
        .op(op), .cond(cond), .mem_ready(mem_ready), .resume(resume),
        .reset_pc(reset_pc), .tsel(tsel), .execb(execb), .rsel(rsel),
        .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
        .load_ir(load_ir), .nsel(nsel), .vsel(vsel), .write(write),
        .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .halted(halted), .fault(fault),
        .retire(retire), .instr_count(instr_count)
    );

    mem_handshake_controller #(.CNT_W(2), .MEM_TIMEOUT(15)) dut_sat (
        .clk(clk), .reset(reset), .status(status), .opcode(opcode),
        .op(op), .cond(cond), .mem_ready(mem_ready), .resume(resume),
        .reset_pc(s_reset_pc), .tsel(s_tsel), .execb(s_execb),
        .rsel(s_rsel), .addr_sel(s_addr_sel), .load_addr(s_load_addr),
        .mem_cmd(s_mem_cmd), .load_ir(s_load_ir), .nsel(s_nsel),
        .vsel(s_vsel), .write(s_write), .asel(s_asel), .bsel(s_bsel),
        .loada(s_loada), .loadb(s_loadb), .loadc(s_loadc),
        .loads(s_loads), .halted(s_halted), .fault(s_fault),
        .retire(s_retire), .instr_count(sat_count)
    );

    always #5 clk = ~clk;

    function automatic bit br_taken(input logic [2:0] c, input logic [2:0] s);
        bit n = s[2];
        bit v = s[1];
        bit z = s[0];
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void encode(input int k, input logic [2:0] c,
                                   output logic [2:0] oc, output logic [1:0] o,
                                   output logic [2:0] cc);
        cc = c;
        case (k)
            K_MOVI:  begin oc = 3'b110; o = 2'b10; end
            K_MOVR:  begin oc = 3'b110; o = 2'b00; end
            K_MVN:   begin oc = 3'b101; o = 2'b11; end
            K_ADD:   begin oc = 3'b101; o = 2'b00; end
            K_AND:   begin oc = 3'b101; o = 2'b10; end
            K_CMP:   begin oc = 3'b101; o = 2'b01; end
            K_LDR:   begin oc = 3'b011; o = 2'b00; end
            K_STR:   begin oc = 3'b100; o = 2'b00; end
            K_B:     begin oc = 3'b001; o = 2'b00; end
            K_BL:    begin oc = 3'b010; o = 2'b11; cc = 3'b111; end
            K_BLX:   begin oc = 3'b010; o = 2'b10; cc = 3'b111; end
            default: begin oc = 3'b010; o = 2'b00; cc = 3'b000; end
        endcase
    endfunction

    // Runs one instruction starting in its IFETCH cycle; memory accesses
    // answer after wi (fetch) and wm (data) low cycles.
    task automatic run_instr(input int k, input logic [2:0] c,
                             input logic [2:0] st, input int wi, input int wm);
        int cnt[16];
        int ev[16];
        int row[12];
        int acc, low, wcyc, bad;
        bit done, t;
        logic [1:0] wv;
        logic [2:0] wn, oc, cc;
        logic [1:0] o;
        foreach (cnt[i]) cnt[i] = 0;
        acc = 0; low = 0; wcyc = 0; bad = 0; done = 0; wv = '0; wn = '0;
        encode(k, c, oc, o, cc);
        for (int n = 1; n <= 80 && !done; n++) begin
            @(negedge clk);
            if (n == 1) begin
                opcode = oc; op = o; cond = cc; status = st;
            end
            resume = 1'($urandom_range(0, 1));
            if (mem_cmd != 2'b00)
                mem_ready = (low >= ((acc == 0) ? wi : wm));
            else
                mem_ready = 1'($urandom_range(0, 1));
            #1;
            cnt[0]++;
            if (mem_cmd == 2'b10) cnt[1]++;
            if (mem_cmd == 2'b01) cnt[2]++;
            if (write) begin
                cnt[3]++; wcyc = n; wv = vsel; wn = nsel;
            end
            cnt[4]  += int'(execb);
            cnt[5]  += int'(tsel);
            cnt[6]  += int'(rsel);
            cnt[7]  += int'(loads);
            cnt[8]  += int'(loada);
            cnt[9]  += int'(loadb);
            cnt[10] += int'(loadc);
            cnt[11] += int'(asel);
            cnt[12] += int'(bsel);
            cnt[13] += int'(load_addr);
            cnt[14] += int'(load_ir);
            cnt[15] += int'(addr_sel);
            if (halted || fault || reset_pc || mem_cmd == 2'b11) bad++;
            if (mem_cmd != 2'b00) begin
                if (mem_ready) begin acc++; low = 0; end
                else low++;
            end
            if (retire) done = 1;
            @(posedge clk);
        end
        resume = 1'b0;
        n_tests++;
        if (!done) begin
            $display("FAIL %s retire: got 0 pulses in 80 cycles, required 1", kname[k]);
            n_fail++;
        end
        exp_count++;
        t = br_taken(cc, st);
        // base, write, execb, tsel, rsel, loads, loada, loadb, loadc, asel, bsel, load_addr
        case (k)
            K_MOVI:  row = '{4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
            K_MOVR:  row = '{6, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0};
            K_MVN:   row = '{6, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
            K_ADD:   row = '{7, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0};
            K_AND:   row = '{7, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0};
            K_CMP:   row = '{6, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
            K_LDR:   row = '{7, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
            K_STR:   row = '{9, 0, 0, 0, 1, 0, 1, 1, 2, 1, 1, 1};
            K_B:     row = '{2, 0, int'(t), 0, int'(!t), 0, 0, 0, 0, 0, 0, 0};
            K_BL:    row = '{3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            K_BLX:   row = '{4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
            default: row = '{3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        endcase
        ev[0] = row[0] + wi + ((k == K_LDR || k == K_STR) ? wm : 0);
        ev[1] = 1 + wi + ((k == K_LDR) ? 1 + wm : 0);
        ev[2] = (k == K_STR) ? 1 + wm : 0;
        for (int i = 3; i <= 13; i++) ev[i] = row[i - 2];
        ev[14] = 1;
        ev[15] = 1 + wi;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (cnt[i] !== ev[i]) begin
                $display("FAIL %s %s: got %0d required %0d",
                         kname[k], cname[i], cnt[i], ev[i]);
                n_fail++;
            end
        end
        if (row[1] == 1) begin
            int ec;
            logic [1:0] evs;
            logic [2:0] ens;
            ec  = (k == K_BL || k == K_BLX) ? 2 + wi : ev[0];
            evs = (k == K_MOVI) ? 2'b10 : (k == K_LDR) ? 2'b11 :
                  (k == K_BL || k == K_BLX) ? 2'b01 : 2'b00;
            ens = (k == K_MOVI || k == K_BL || k == K_BLX) ? 3'b100 : 3'b010;
            n_tests++;
            if (wcyc !== ec || wv !== evs || wn !== ens) begin
                $display("FAIL %s write_port: got cyc %0d vsel %b nsel %b required cyc %0d vsel %b nsel %b",
                         kname[k], wcyc, wv, wn, ec, evs, ens);
                n_fail++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            $display("FAIL %s status_outs: got %0d bad cycles required 0", kname[k], bad);
            n_fail++;
        end
        #1;
        n_tests++;
        if (instr_count !== 16'(exp_count)) begin
            $display("FAIL %s instr_count: got %0d required %0d", kname[k], instr_count, exp_count);
            n_fail++;
        end
        n_tests++;
        if (sat_count !== 2'((exp_count > 3) ? 3 : exp_count)) begin
            $display("FAIL %s sat_count: got %0d required %0d", kname[k], sat_count,
                     (exp_count > 3) ? 3 : exp_count);
            n_fail++;
        end
    endtask

    task automatic test_reset;
        logic [21:0] rest;
        @(negedge clk);
        reset = 1'b1;
        resume = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rest = {tsel, execb, addr_sel, load_addr, mem_cmd, load_ir, nsel, vsel,
                write, asel, bsel, loada, loadb, loadc, loads, halted, fault, retire};
        n_tests++;
        if ({reset_pc, rsel} !== 2'b11) begin
            $display("FAIL reset pc_ctrl: got %b required 11", {reset_pc, rsel});
            n_fail++;
        end
        n_tests++;
        if (rest !== 22'd0) begin
            $display("FAIL reset others: got %h required 0", rest);
            n_fail++;
        end
        n_tests++;
        if (instr_count !== 16'd0 || sat_count !== 2'd0) begin
            $display("FAIL reset count: got %0d/%0d required 0/0", instr_count, sat_count);
            n_fail++;
        end
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        resume = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_mov_imm;
        run_instr(K_MOVI, 3'd0, 3'd0, 0, 0);
    endtask

    task automatic test_ldr_wait;
        run_instr(K_LDR, 3'd0, 3'd0, 0, 3);
    endtask

    task automatic test_branch;
        run_instr(K_B, 3'b011, 3'b100, 0, 0);
        run_instr(K_B, 3'b011, 3'b101, 0, 0);
        run_instr(K_B, 3'b011, 3'b000, 0, 0);
    endtask

    task automatic test_wait_boundary;
        run_instr(K_MOVI, 3'd0, 3'd0, 14, 0);
        run_instr(K_LDR, 3'd0, 3'd0, 0, 14);
        run_instr(K_STR, 3'd0, 3'd0, 2, 14);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++)
            run_instr($urandom_range(0, 11), 3'($urandom), 3'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 4));
    endtask

    task automatic test_halt(input bit early);
        int cyc;
        bit done;
        cyc = 0; done = 0;
        for (int n = 1; n <= 30 && !done; n++) begin
            @(negedge clk);
            if (n == 1) begin
                opcode = 3'b111; op = 2'($urandom); cond = 3'($urandom);
            end
            resume = early;
            mem_ready = (mem_cmd != 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (retire) begin done = 1; cyc = n; end
            @(posedge clk);
        end
        exp_count++;
        n_tests++;
        if (!done || cyc != 3) begin
            $display("FAIL hlt_cycles: got %0d required 3", cyc);
            n_fail++;
        end
        #1;
        n_tests++;
        if (halted !== 1'b1 || mem_cmd !== 2'b00 || instr_count !== 16'(exp_count)) begin
            $display("FAIL hlt_enter: got halted %b cmd %b cnt %0d required 1 00 %0d",
                     halted, mem_cmd, instr_count, exp_count);
            n_fail++;
        end
        if (!early) begin
            repeat (3) begin
                @(negedge clk);
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                n_tests++;
                if (halted !== 1'b1 || mem_cmd !== 2'b00) begin
                    $display("FAIL hlt_hold: got halted %b cmd %b required 1 00", halted, mem_cmd);
                    n_fail++;
                end
            end
            @(negedge clk);
            resume = 1'b1;
            #1;
            n_tests++;
            if (halted !== 1'b1) begin
                $display("FAIL hlt_resume_cycle: got halted %b required 1", halted);
                n_fail++;
            end
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (halted !== 1'b0 || mem_cmd !== 2'b10) begin
            $display("FAIL hlt_exit: got halted %b cmd %b required 0 10", halted, mem_cmd);
            n_fail++;
        end
        resume = 1'b0;
    endtask

    task automatic test_fault_decode;
        int r;
        r = 0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) begin opcode = 3'b110; op = 2'b01; cond = 3'd0; end
            mem_ready = 1'b1;
            resume = 1'b0;
            #1;
            r += int'(retire);
            @(posedge clk);
        end
        #1;
        n_tests++;
        if (r != 0 || fault !== 1'b1 || mem_cmd !== 2'b00) begin
            $display("FAIL bad_op_fault: got retires %0d fault %b cmd %b required 0 1 00",
                     r, fault, mem_cmd);
            n_fail++;
        end
        repeat (4) begin
            @(negedge clk);
            mem_ready = 1'b1;
            resume = 1'b1;
            #1;
            n_tests++;
            if (fault !== 1'b1 || mem_cmd !== 2'b00 || halted !== 1'b0 || retire !== 1'b0) begin
                $display("FAIL fault_hold: got fault %b cmd %b halted %b retire %b required 1 00 0 0",
                         fault, mem_cmd, halted, retire);
                n_fail++;
            end
        end
        n_tests++;
        if (instr_count !== 16'(exp_count)) begin
            $display("FAIL fault_count: got %0d required %0d", instr_count, exp_count);
            n_fail++;
        end
        test_reset();
    endtask

    task automatic test_timeout;
        int stw, r;
        bit seen;
        stw = 0; r = 0; seen = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) begin opcode = 3'b100; op = 2'b00; cond = 3'd0; end
            resume = 1'b0;
            mem_ready = (mem_cmd == 2'b01) ? 1'b0 : 1'b1;
            #1;
            if (fault) seen = 1;
            else if (mem_cmd == 2'b01) stw++;
            r += int'(retire);
            @(posedge clk);
        end
        n_tests++;
        if (!seen || stw != 15 || r != 0) begin
            $display("FAIL timeout: got fault %b after %0d write cycles, retires %0d; required 1 after 15, 0",
                     seen, stw, r);
            n_fail++;
        end
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_tests++;
            if (fault !== 1'b1 || mem_cmd !== 2'b00) begin
                $display("FAIL timeout_hold: got fault %b cmd %b required 1 00", fault, mem_cmd);
                n_fail++;
            end
        end
        test_reset();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) run_instr(K_MOVI, 3'd0, 3'd0, 0, 0);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) begin opcode = 3'b110; op = 2'b10; end
            mem_ready = 1'b0;
            #1;
            n_tests++;
            if (mem_cmd !== 2'b10 || addr_sel !== 1'b1) begin
                $display("FAIL fetch_wait_hold: got cmd %b addr_sel %b required 10 1", mem_cmd, addr_sel);
                n_fail++;
            end
            @(posedge clk);
        end
        test_reset();
        run_instr(K_ADD, 3'd0, 3'd0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_ldr_wait();
        test_branch();
        test_wait_boundary();
        test_halt(1'b0);
        test_halt(1'b1);
        test_random();
        test_fault_decode();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
